// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write-side FIFO, programmable baud prescaler,
// optional even/odd parity and one or two stop bits. Frame settings are
// latched when a word is popped, so they cannot change partway through a frame.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         p_data,
  input  logic                          data_valid,
  output logic                          ready,
  input  logic                          par_en,
  input  logic                          par_type,
  input  logic                          stop2,
  input  logic [PRESCALE_WIDTH-1:0]     prescale,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  // FIFO storage and pointers (one extra MSB distinguishes full from empty)
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, rd_ptr_q;
  logic                  wr_en, pop, empty;
  logic [DATA_WIDTH-1:0] head;

  // Transmit state
  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] p_q, p_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic                      par_en_q, par_en_d;
  logic                      par_bit_q, par_bit_d;
  logic                      stop2_q, stop2_d;
  logic                      second_q, second_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      tick;
  logic [PRESCALE_WIDTH-1:0] p_eff;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign ready      = !((wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]));
  assign wr_en      = data_valid && ready;
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign tick       = (cnt_q == p_q - 1'b1);
  assign p_eff      = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
  assign tx_out     = tx_q;
  assign busy       = busy_q;

  // FIFO data array; contents need no reset since pointers gate all reads
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= p_data;
  end

  // FIFO pointers; a write and a pop on the same edge both take effect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Transmit FSM state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      p_q       <= PRESCALE_WIDTH'(1);
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      second_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      second_q  <= second_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; tx/busy are computed for the state being entered so
  // the registered outputs line up with the state register
  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    p_d       = p_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    second_d  = second_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!empty) pop = 1'b1;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d  = STOP;
              tx_d     = 1'b1;
              second_d = 1'b0;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d  = STOP;
          tx_d     = 1'b1;
          second_d = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop2_q && !second_q) begin
            second_d = 1'b1;
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Pop from IDLE or end of STOP: load the word and latch frame settings
    if (pop) begin
      state_d   = START;
      cnt_d     = '0;
      shift_d   = head;
      par_en_d  = par_en;
      par_bit_d = (^head) ^ par_type;
      stop2_d   = stop2;
      p_d       = p_eff;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus pushes the expected per-cycle
// line waveform of each accepted word; a monitor captures each frame from its
// start bit and compares the line and busy against the queued expectation.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       ready;
  logic       par_en;
  logic       par_type;
  logic       stop2;
  logic [7:0] prescale;
  logic       tx_out;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx_fifo #(
    .DATA_WIDTH     (8),
    .FIFO_DEPTH     (4),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .ready      (ready),
    .par_en     (par_en),
    .par_type   (par_type),
    .stop2      (stop2),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] bits;
    int           len;
    int           id;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   next_id = 0;

  // Monitor state
  bit           in_frame = 0;
  exp_t         cur;
  int           idx;
  logic [127:0] got_tx, got_busy;

  // Busy run-length tracker
  int run = 0;
  int last_run = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] build(input logic [7:0] d, input logic pe,
                                         input logic pt, input int p);
    logic [127:0] v;
    int n;
    v = '1;
    n = 0;
    for (int c = 0; c < p; c++) begin v[n] = 1'b0; n++; end
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < p; c++) begin v[n] = d[b]; n++; end
    if (pe)
      for (int c = 0; c < p; c++) begin v[n] = (^d) ^ pt; n++; end
    return v;
  endfunction

  task automatic push_bits(input logic [127:0] bits, input int len);
    exp_t e;
    e.bits = bits;
    e.len  = len;
    e.id   = next_id;
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic s2, input int p);
    push_bits(build(d, pe, pt, p), p * (1 + 8 + int'(pe) + 1 + int'(s2)));
  endtask

  task automatic write_word(input logic [7:0] d);
    @(negedge clk);
    p_data     = d;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (t < 4000 && !(exp_q.size() == 0 && !in_frame && busy === 1'b0 && fifo_count == 3'd0)) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got pending=%0d busy=%b expected drained", name, exp_q.size(), busy);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Frame monitor: starts capture on a low line, compares once the expected length is seen
  always @(negedge clk) begin
    if (!rst) begin
      in_frame = 0;
    end else if (!in_frame) begin
      if (tx_out === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: got tx_out=0 expected idle line");
        end else begin
          cur = exp_q.pop_front();
          in_frame = 1;
          got_tx = '1;
          got_busy = '0;
          got_tx[0] = tx_out;
          got_busy[0] = busy;
          idx = 1;
        end
      end
    end else begin
      got_tx[idx] = tx_out;
      got_busy[idx] = busy;
      idx++;
      if (idx == cur.len) begin
        logic [127:0] mask;
        mask = (128'd1 << cur.len) - 128'd1;
        n_cmp++;
        if ((got_tx & mask) !== (cur.bits & mask)) begin
          n_bad++;
          $display("FAIL frame%0d_line: got %0h expected %0h", cur.id, got_tx & mask, cur.bits & mask);
        end
        n_cmp++;
        if ((got_busy & mask) !== mask) begin
          n_bad++;
          $display("FAIL frame%0d_busy: got %0h expected %0h", cur.id, got_busy & mask, mask);
        end
        in_frame = 0;
      end
    end
  end

  // Length of the most recent contiguous busy run
  always @(negedge clk) begin
    if (!rst) run = 0;
    else if (busy === 1'b1) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; p_data = '0; data_valid = 1'b0;
    par_en = 1'b1; par_type = 1'b0; stop2 = 1'b0; prescale = 8'd1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_out), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(ready), 1);
    check("rst_count", 32'(fifo_count), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: 0xA5, even parity, one stop, P=1
    last_run = -1;
    push_bits(128'b101_0100_1010, 11);
    write_word(8'hA5);
    wait_drain("t1");
    check("t1_busy_len", 32'(last_run), 11);

    // Test 2: odd parity, then no parity
    par_type = 1'b1;
    last_run = -1;
    push_bits(128'b111_0100_1010, 11);
    write_word(8'hA5);
    wait_drain("t2a");
    check("t2a_busy_len", 32'(last_run), 11);
    par_en = 1'b0;
    last_run = -1;
    push_bits(128'b11_0100_1010, 10);
    write_word(8'hA5);
    wait_drain("t2b");
    check("t2b_busy_len", 32'(last_run), 10);

    // Test 3: P=4, two stop bits; then prescale=0 behaves as 1
    par_en = 1'b1; par_type = 1'b0; stop2 = 1'b1; prescale = 8'd4;
    last_run = -1;
    push_frame(8'h3C, 1'b1, 1'b0, 1'b1, 4);
    write_word(8'h3C);
    wait_drain("t3a");
    check("t3a_busy_len", 32'(last_run), 48);
    stop2 = 1'b0; prescale = 8'd0;
    last_run = -1;
    push_bits(128'b101_0100_1010, 11);
    write_word(8'hA5);
    wait_drain("t3b");
    check("t3b_busy_len", 32'(last_run), 11);

    // Test 4: six writes on consecutive edges; the sixth meets a full FIFO
    prescale = 8'd1;
    last_run = -1;
    begin
      logic [7:0] words [6];
      logic       rdy_exp [6];
      words = '{8'h01, 8'h82, 8'h43, 8'hC4, 8'h25, 8'hE6};
      rdy_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) push_frame(words[i], 1'b1, 1'b0, 1'b0, 1);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        p_data = words[i];
        data_valid = 1'b1;
        check($sformatf("t4_ready_w%0d", i), 32'(ready), 32'(rdy_exp[i]));
      end
      @(negedge clk);
      data_valid = 1'b0;
      check("t4_count_full", 32'(fifo_count), 4);
      check("t4_ready_full", 32'(ready), 0);
    end
    wait_drain("t4");
    check("t4_busy_len", 32'(last_run), 55);
    check("t4_count_end", 32'(fifo_count), 0);

    // Test 5: settings change mid-frame only affect the following frame
    prescale = 8'd2; par_en = 1'b1; par_type = 1'b0; stop2 = 1'b0;
    last_run = -1;
    push_frame(8'h5A, 1'b1, 1'b0, 1'b0, 2);
    push_frame(8'hC3, 1'b1, 1'b1, 1'b1, 2);
    @(negedge clk); p_data = 8'h5A; data_valid = 1'b1;
    @(negedge clk); p_data = 8'hC3;
    @(negedge clk); data_valid = 1'b0;
    repeat (6) @(negedge clk);
    par_type = 1'b1; stop2 = 1'b1;
    wait_drain("t5");
    check("t5_busy_len", 32'(last_run), 46);

    // Test 6: reset mid-DATA with two words queued
    par_type = 1'b0; stop2 = 1'b0; prescale = 8'd4;
    push_frame(8'h11, 1'b1, 1'b0, 1'b0, 4);
    @(negedge clk); p_data = 8'h11; data_valid = 1'b1;
    @(negedge clk); p_data = 8'h22;
    @(negedge clk); p_data = 8'h33;
    @(negedge clk); data_valid = 1'b0;
    check("t6_count_pre", 32'(fifo_count), 2);
    repeat (6) @(negedge clk);
    check("t6_busy_pre", 32'(busy), 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_tx", 32'(tx_out), 1);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_count", 32'(fifo_count), 0);
    check("t6_rst_ready", 32'(ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("t6_quiet_tx", 32'(tx_out), 1);
    check("t6_quiet_busy", 32'(busy), 0);
    check("t6_quiet_count", 32'(fifo_count), 0);
    prescale = 8'd1;
    last_run = -1;
    push_frame(8'h81, 1'b1, 1'b0, 1'b0, 1);
    write_word(8'h81);
    wait_drain("t6");
    check("t6_busy_len", 32'(last_run), 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
